// File: rtl/clock_controller.sv
`default_nettype none
// clock_controller: CPU clock source -- free-run divider, single-step button, halt/resume.
// Define CLKCTL_DEBOUNCE_EN to add a DEB_CNT-sample debounce filter on the step button.
module clock_controller #(
  parameter int DIV_W   = 16,
  parameter int DEB_CNT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select,
  input  logic             hlt,
  input  logic             push,
  input  logic             resume,
  input  logic [DIV_W-1:0] div,
  output logic             clk_en,
  output logic             clk_out,
  output logic             halted,
  output logic [1:0]       mode,
  output logic [15:0]      tick_cnt
);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             halted_q, halted_d;
  logic             clk_out_q, clk_out_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic             sync1_q, sync2_q;
  logic             prev_q;
  logic             btn_level;
  logic             rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= push;
      sync2_q <= sync1_q;
    end
  end

`ifdef CLKCTL_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;

  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Level only follows the synchronizer after DEB_CNT consecutive differing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CNT - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign btn_level = deb_q;
`else
  logic deb_unused;
  assign deb_unused = (DEB_CNT == 0);
  assign btn_level  = sync2_q;
`endif

  // Edge tracking runs in every state so a press held across a mode change never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= btn_level;
  end

  assign rise = btn_level & ~prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    clk_en_d = 1'b0;
    if (hlt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        MANUAL: begin
          if (select) state_d = RUN;
          else        clk_en_d = rise;
        end
        RUN: begin
          if (!select) begin
            state_d = MANUAL;
          end else if (cnt_q >= div) begin
            clk_en_d = 1'b1;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        HALTED: begin
          if (resume) state_d = select ? RUN : MANUAL;
        end
        default: state_d = MANUAL;
      endcase
    end
    halted_d   = (state_d == HALTED);
    clk_out_d  = clk_out_q ^ clk_en_q;
    tick_cnt_d = tick_cnt_q + {15'd0, clk_en_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MANUAL;
      cnt_q      <= '0;
      clk_en_q   <= 1'b0;
      halted_q   <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      halted_q   <= halted_d;
      clk_out_q  <= clk_out_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign clk_en   = clk_en_q;
  assign clk_out  = clk_out_q;
  assign halted   = halted_q;
  assign mode     = state_q;
  assign tick_cnt = tick_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_controller.sv
`default_nettype none
// tb_clock_controller: directed self-checking bench for clock_controller (default build).
module tb_clock_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        select = 1'b0;
  logic        hlt = 1'b0;
  logic        push = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] div = 16'd0;
  logic        clk_en;
  logic        clk_out;
  logic        halted;
  logic [1:0]  mode;
  logic [15:0] tick_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  clock_controller dut (
    .clk      (clk),
    .rst      (rst),
    .select   (select),
    .hlt      (hlt),
    .push     (push),
    .resume   (resume),
    .div      (div),
    .clk_en   (clk_en),
    .clk_out  (clk_out),
    .halted   (halted),
    .mode     (mode),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; select = 1'b0; hlt = 1'b0; push = 1'b0; resume = 1'b0; div = 16'd0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en: got %b want 0", clk_en); end
    n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", mode); end
    n_checks++; if (tick_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_tick_cnt: got %0d want 0", tick_cnt); end
  endtask

  task automatic test_run_div3();
    int pulses;
    do_reset();
    div = 16'd3; select = 1'b1;
    step(1);
    n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL run_entry_mode: got %b want 01", mode); end
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (clk_en === 1'b1) pulses++;
      n_checks++;
      if (clk_en !== ((i % 4) == 0)) begin
        n_fail++; $display("FAIL run_div3_clk_en[%0d]: got %b want %b", i, clk_en, (i % 4) == 0);
      end
    end
    n_checks++; if (pulses != 5) begin n_fail++; $display("FAIL run_div3_pulses: got %0d want 5", pulses); end
    step(1);
    n_checks++; if (tick_cnt !== 16'd5) begin n_fail++; $display("FAIL run_div3_tick_cnt: got %0d want 5", tick_cnt); end
    n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL run_div3_clk_out: got %b want 1", clk_out); end
  endtask

  task automatic test_manual_step();
    int extra;
    do_reset();
    push = 1'b1;
    step(1);
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL manual_edge1: got %b want 0", clk_en); end
    step(1);
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL manual_edge2: got %b want 0", clk_en); end
    step(1);
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL manual_edge3: got %b want 1", clk_en); end
    extra = 0;
    for (int i = 0; i < 47; i++) begin
      step(1);
      if (clk_en === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL manual_hold_repeat: got %0d extra pulses want 0", extra); end
    n_checks++; if (tick_cnt !== 16'd1) begin n_fail++; $display("FAIL manual_tick_cnt: got %0d want 1", tick_cnt); end
    n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL manual_clk_out: got %b want 1", clk_out); end
    push = 1'b0;
    step(3);
  endtask

  task automatic test_held_across_state();
    int pulses;
    do_reset();
    div = 16'd1000; select = 1'b1;
    step(1);
    push = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (clk_en === 1'b1) pulses++;
    end
    select = 1'b0;
    step(1);
    n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL held_mode: got %b want 00", mode); end
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (clk_en === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL held_no_pulse: got %0d pulses want 0", pulses); end
    push = 1'b0;
    step(3);
    push = 1'b1;
    step(2);
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL fresh_press_early: got %b want 0", clk_en); end
    step(1);
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL fresh_press_pulse: got %b want 1", clk_en); end
    push = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    div = 16'd0; select = 1'b1;
    step(1);
    step(9);
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL halt_pre_clk_en: got %b want 1", clk_en); end
    hlt = 1'b1;
    step(1);
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL halt_clk_en: got %b want 0", clk_en); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %b want 1", halted); end
    n_checks++; if (mode !== 2'b10) begin n_fail++; $display("FAIL halt_mode: got %b want 10", mode); end
    hlt = 1'b0;
    step(2);
    n_checks++; if (mode !== 2'b10) begin n_fail++; $display("FAIL halt_no_resume_mode: got %b want 10", mode); end
    hlt = 1'b1; resume = 1'b1;
    step(2);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_resume_hlt_halted: got %b want 1", halted); end
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL halt_resume_hlt_clk_en: got %b want 0", clk_en); end
    hlt = 1'b0;
    step(1);
    n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL resume_mode: got %b want 01", mode); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL resume_halted: got %b want 0", halted); end
    resume = 1'b0;
    step(1);
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL resume_clk_en: got %b want 1", clk_en); end
  endtask

  task automatic test_div_change();
    logic [9:0] exp_pat;
    do_reset();
    div = 16'd100; select = 1'b1;
    step(1);
    step(7);
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL divchg_pre: got %b want 0", clk_en); end
    div = 16'd2;
    exp_pat = 10'b1001001001;
    for (int i = 9; i >= 0; i--) begin
      step(1);
      n_checks++;
      if (clk_en !== exp_pat[i]) begin
        n_fail++; $display("FAIL divchg_clk_en[%0d]: got %b want %b", 9 - i, clk_en, exp_pat[i]);
      end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    div = 16'd0; select = 1'b1;
    step(1);
    step(65536);
    n_checks++; if (tick_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", tick_cnt); end
    step(1);
    n_checks++; if (tick_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", tick_cnt); end
    step(3);
    n_checks++; if (tick_cnt !== 16'd3) begin n_fail++; $display("FAIL pre_async_tick: got %0d want 3", tick_cnt); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL async_clk_en: got %b want 0", clk_en); end
    n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL async_mode: got %b want 00", mode); end
    n_checks++; if (tick_cnt !== 16'd0) begin n_fail++; $display("FAIL async_tick_cnt: got %0d want 0", tick_cnt); end
    n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL async_clk_out: got %b want 0", clk_out); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL async_halted: got %b want 0", halted); end
    step(1);
    rst = 1'b0; select = 1'b0;
    step(2);
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_clk_en: got %b want 0", clk_en); end
  endtask

  initial begin
    test_reset();
    test_run_div3();
    test_manual_step();
    test_held_across_state();
    test_halt();
    test_div_change();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
